cluster_feeder: RTL and testbench

Transmit-side driver for one 3x3 PE cluster's multicast and ID-scan inputs. It buffers a full set of multicast-controller IDs and shifts them into the cluster scan chains as one contiguous burst, then commits them. It then streams tagged weight and activation words onto the cluster data buses, triggers compute, and waits for the cluster's done flag. It sits between the global buffer/host sequencer and the cluster.

---
 rtl/cluster_feeder.sv | 217 +++++++++++++++++++++
 tb/tb_cluster_feeder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_feeder.sv
// cluster_feeder
// Transmit-side driver for one 3x3 PE cluster. A job collects one full set of
// multicast-controller ID pairs, scans them into the cluster ID chains as one
// contiguous burst, commits them, then streams tagged weight/activation words
// onto the cluster buses, triggers compute and waits for the done flag.
//
// Ports
//   clk, nrst                     clock, synchronous active-low reset
//   go_i, load_len_i              job start (idle only) and data word count
//   id_valid_i/id_ready_o         ID stream handshake, id_act_i/id_weight_i payload
//   d_valid_i/d_ready_o           data stream handshake
//   d_is_weight_i, d_tag_x_i, d_tag_y_i, d_data_i   data word and target tags
//   act_id_scan_o/weight_id_scan_o                  scan chain inputs
//   act_id_wren_o/weight_id_wren_o                  ID commit strobes
//   a_data_o/w_data_o, act_tag_*_o, weight_tag_*_o  registered cluster buses
//   cluster_enable_o, start_compute_o, flag_done_i  cluster control
//   busy_o, done_o                job status
module cluster_feeder #(
    parameter int numPeX = 3,
    parameter int numPeY = 3,
    parameter int dataSize = 8,
    parameter int idSize = 8,
    parameter logic [idSize-1:0] nullTag = {idSize{1'b1}}
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       go_i,
    input  logic [15:0]                load_len_i,
    input  logic                       id_valid_i,
    output logic                       id_ready_o,
    input  logic [idSize-1:0]          id_act_i,
    input  logic [idSize-1:0]          id_weight_i,
    input  logic                       d_valid_i,
    output logic                       d_ready_o,
    input  logic                       d_is_weight_i,
    input  logic [idSize-1:0]          d_tag_x_i,
    input  logic [idSize-1:0]          d_tag_y_i,
    input  logic signed [dataSize-1:0] d_data_i,
    output logic [idSize-1:0]          act_id_scan_o,
    output logic [idSize-1:0]          weight_id_scan_o,
    output logic                       act_id_wren_o,
    output logic                       weight_id_wren_o,
    output logic signed [dataSize-1:0] a_data_o,
    output logic signed [dataSize-1:0] w_data_o,
    output logic [idSize-1:0]          act_tag_x_o,
    output logic [idSize-1:0]          act_tag_y_o,
    output logic [idSize-1:0]          weight_tag_x_o,
    output logic [idSize-1:0]          weight_tag_y_o,
    output logic                       cluster_enable_o,
    output logic                       start_compute_o,
    input  logic                       flag_done_i,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int N = numPeX * numPeY + numPeY;
    localparam int IDX_W = $clog2(N);
    localparam logic [15:0] LAST = 16'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_SHIFT  = 3'd2,
        S_COMMIT = 3'd3,
        S_LOAD   = 3'd4,
        S_START  = 3'd5,
        S_WAIT   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t state_q, state_d;
    logic [15:0] len_q, len_d;
    // Shared counter: ID fill index, shift cycle, then accepted data words.
    logic [15:0] cnt_q, cnt_d;

    logic [idSize-1:0] act_buf_q [N];
    logic [idSize-1:0] act_buf_d [N];
    logic [idSize-1:0] weight_buf_q [N];
    logic [idSize-1:0] weight_buf_d [N];

    logic signed [dataSize-1:0] a_data_q, a_data_d, w_data_q, w_data_d;
    logic [idSize-1:0] act_tag_x_q, act_tag_x_d, act_tag_y_q, act_tag_y_d;
    logic [idSize-1:0] weight_tag_x_q, weight_tag_x_d, weight_tag_y_q, weight_tag_y_d;

    logic [IDX_W-1:0] fill_idx;
    logic [IDX_W-1:0] shift_idx;

    assign fill_idx  = cnt_q[IDX_W-1:0];
    // Highest slot goes out first so that slot 0, presented last, lands at
    // chain index 0 once the whole burst has shifted in.
    assign shift_idx = LAST[IDX_W-1:0] - cnt_q[IDX_W-1:0];

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        act_buf_d      = act_buf_q;
        weight_buf_d   = weight_buf_q;
        a_data_d       = '0;
        w_data_d       = '0;
        act_tag_x_d    = nullTag;
        act_tag_y_d    = nullTag;
        weight_tag_x_d = nullTag;
        weight_tag_y_d = nullTag;
        id_ready_o     = 1'b0;
        d_ready_o      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    len_d   = load_len_i;
                    cnt_d   = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                id_ready_o = 1'b1;
                if (id_valid_i) begin
                    act_buf_d[fill_idx]    = id_act_i;
                    weight_buf_d[fill_idx] = id_weight_i;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_SHIFT: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_COMMIT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_COMMIT: begin
                cnt_d   = '0;
                state_d = (len_q == 16'd0) ? S_START : S_LOAD;
            end
            S_LOAD: begin
                d_ready_o = (cnt_q < len_q);
                if (d_ready_o && d_valid_i) begin
                    cnt_d = cnt_q + 16'd1;
                    if (d_is_weight_i) begin
                        w_data_d       = d_data_i;
                        weight_tag_x_d = d_tag_x_i;
                        weight_tag_y_d = d_tag_y_i;
                    end else begin
                        a_data_d    = d_data_i;
                        act_tag_x_d = d_tag_x_i;
                        act_tag_y_d = d_tag_y_i;
                    end
                    if (cnt_d == len_q) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (flag_done_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q        <= S_IDLE;
            len_q          <= '0;
            cnt_q          <= '0;
            a_data_q       <= '0;
            w_data_q       <= '0;
            act_tag_x_q    <= nullTag;
            act_tag_y_q    <= nullTag;
            weight_tag_x_q <= nullTag;
            weight_tag_y_q <= nullTag;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            a_data_q       <= a_data_d;
            w_data_q       <= w_data_d;
            act_tag_x_q    <= act_tag_x_d;
            act_tag_y_q    <= act_tag_y_d;
            weight_tag_x_q <= weight_tag_x_d;
            weight_tag_y_q <= weight_tag_y_d;
        end
    end

    // ID buffer contents are only meaningful after a complete fill, so they
    // carry no reset.
    always_ff @(posedge clk) begin
        act_buf_q    <= act_buf_d;
        weight_buf_q <= weight_buf_d;
    end

    assign act_id_scan_o    = (state_q == S_SHIFT) ? act_buf_q[shift_idx] : '0;
    assign weight_id_scan_o = (state_q == S_SHIFT) ? weight_buf_q[shift_idx] : '0;
    assign act_id_wren_o    = (state_q == S_COMMIT);
    assign weight_id_wren_o = (state_q == S_COMMIT);
    assign start_compute_o  = (state_q == S_START);
    assign done_o           = (state_q == S_DONE);
    assign busy_o           = (state_q != S_IDLE);
    assign cluster_enable_o = (state_q != S_IDLE);

    assign a_data_o       = a_data_q;
    assign w_data_o       = w_data_q;
    assign act_tag_x_o    = act_tag_x_q;
    assign act_tag_y_o    = act_tag_y_q;
    assign weight_tag_x_o = weight_tag_x_q;
    assign weight_tag_y_o = weight_tag_y_q;

endmodule

// File: tb/tb_cluster_feeder.sv
// Bench for cluster_feeder: a queue-based job model checked every cycle,
// a 12-stage chain model fed by the scan outputs, and directed scenarios.
module tb_cluster_feeder;

    localparam int N = 12;

    logic clk = 1'b0;
    logic nrst;
    logic go_i;
    logic [15:0] load_len_i;
    logic id_valid_i, id_ready_o;
    logic [7:0] id_act_i, id_weight_i;
    logic d_valid_i, d_ready_o, d_is_weight_i;
    logic [7:0] d_tag_x_i, d_tag_y_i;
    logic signed [7:0] d_data_i;
    logic [7:0] act_id_scan_o, weight_id_scan_o;
    logic act_id_wren_o, weight_id_wren_o;
    logic signed [7:0] a_data_o, w_data_o;
    logic [7:0] act_tag_x_o, act_tag_y_o, weight_tag_x_o, weight_tag_y_o;
    logic cluster_enable_o, start_compute_o, flag_done_i, busy_o, done_o;

    cluster_feeder dut (
        .clk(clk), .nrst(nrst), .go_i(go_i), .load_len_i(load_len_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_act_i(id_act_i), .id_weight_i(id_weight_i),
        .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_is_weight_i(d_is_weight_i),
        .d_tag_x_i(d_tag_x_i), .d_tag_y_i(d_tag_y_i), .d_data_i(d_data_i),
        .act_id_scan_o(act_id_scan_o), .weight_id_scan_o(weight_id_scan_o),
        .act_id_wren_o(act_id_wren_o), .weight_id_wren_o(weight_id_wren_o),
        .a_data_o(a_data_o), .w_data_o(w_data_o),
        .act_tag_x_o(act_tag_x_o), .act_tag_y_o(act_tag_y_o),
        .weight_tag_x_o(weight_tag_x_o), .weight_tag_y_o(weight_tag_y_o),
        .cluster_enable_o(cluster_enable_o), .start_compute_o(start_compute_o),
        .flag_done_i(flag_done_i), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_FILL = 1, P_SHIFT = 2, P_COMMIT = 3;
    localparam int P_LOAD = 4, P_START = 5, P_WAIT = 6, P_DONE = 7;

    int ph = P_IDLE;
    int m_len, m_cnt;
    bit m_ok = 0;
    logic [7:0] qa[$];
    logic [7:0] qw[$];
    logic [23:0] e_abus, e_wbus;   // {data, tag_x, tag_y}
    int cyc = 0;

    logic [7:0] ch_a [N];
    logic [7:0] ch_w [N];
    logic [7:0] snap_a [N];
    logic [7:0] snap_w [N];
    logic [7:0] sa_cur, sw_cur;

    always @(posedge clk) begin
        logic [23:0] na, nw;
        cyc++;
        // Chain entry at index 0; the value presented last stays at index 0.
        for (int k = N - 1; k > 0; k--) begin
            ch_a[k] = ch_a[k-1];
            ch_w[k] = ch_w[k-1];
        end
        ch_a[0] = sa_cur;
        ch_w[0] = sw_cur;

        na = 24'h00FFFF;
        nw = 24'h00FFFF;
        if (!nrst) begin
            ph = P_IDLE;
            qa.delete();
            qw.delete();
            m_ok = 1;
        end else begin
            case (ph)
                P_IDLE: if (go_i) begin
                    m_len = int'(load_len_i);
                    qa.delete();
                    qw.delete();
                    ph = P_FILL;
                end
                P_FILL: if (id_valid_i) begin
                    qa.push_back(id_act_i);
                    qw.push_back(id_weight_i);
                    if (qa.size() == N) ph = P_SHIFT;
                end
                P_SHIFT: begin
                    void'(qa.pop_back());
                    void'(qw.pop_back());
                    if (qa.size() == 0) ph = P_COMMIT;
                end
                P_COMMIT: begin
                    m_cnt = 0;
                    ph = (m_len == 0) ? P_START : P_LOAD;
                end
                P_LOAD: if (d_valid_i) begin
                    if (d_is_weight_i) nw = {d_data_i, d_tag_x_i, d_tag_y_i};
                    else na = {d_data_i, d_tag_x_i, d_tag_y_i};
                    m_cnt++;
                    if (m_cnt == m_len) ph = P_START;
                end
                P_START: ph = P_WAIT;
                P_WAIT: if (flag_done_i) ph = P_DONE;
                default: ph = P_IDLE;
            endcase
        end
        e_abus = na;
        e_wbus = nw;
    end

    // ---------------- compare process ----------------
    int wren_cnt, wren_cyc, start_cyc, dr_cyc;
    bit wren_seen, start_seen, dr_seen;

    always @(negedge clk) begin
        logic [7:0] ec;
        logic [15:0] es;
        if (m_ok) begin
            ec = {ph != P_IDLE, ph != P_IDLE, ph == P_FILL, ph == P_LOAD,
                  ph == P_COMMIT, ph == P_COMMIT, ph == P_START, ph == P_DONE};
            es = (ph == P_SHIFT) ? {qa[$], qw[$]} : 16'h0000;
            chk("ctrl", {busy_o, cluster_enable_o, id_ready_o, d_ready_o, act_id_wren_o,
                         weight_id_wren_o, start_compute_o, done_o}, ec);
            chk("scan", {act_id_scan_o, weight_id_scan_o}, es);
            chk("wbus", {w_data_o, weight_tag_x_o, weight_tag_y_o}, e_wbus);
            chk("abus", {a_data_o, act_tag_x_o, act_tag_y_o}, e_abus);
        end
        if (act_id_wren_o) begin
            wren_cnt++;
            wren_cyc = cyc;
            wren_seen = 1;
            snap_a = ch_a;
            snap_w = ch_w;
        end
        if (start_compute_o) begin
            start_cyc = cyc;
            start_seen = 1;
        end
        if (d_ready_o && !dr_seen) begin
            dr_cyc = cyc;
            dr_seen = 1;
        end
        sa_cur = act_id_scan_o;
        sw_cur = weight_id_scan_o;
    end

    // ---------------- stimulus ----------------
    int go_cyc;

    task automatic clear_events();
        wren_cnt = 0;
        wren_seen = 0;
        start_seen = 0;
        dr_seen = 0;
    endtask

    task automatic start_job(input logic [15:0] len);
        clear_events();
        go_i = 1'b1;
        load_len_i = len;
        go_cyc = cyc;
        @(negedge clk);
        go_i = 1'b0;
    endtask

    task automatic send_ids(input int gap, input logic [7:0] ba, input logic [7:0] bw);
        for (int k = 0; k < N; k++) begin
            int t;
            t = 0;
            id_valid_i = 1'b1;
            id_act_i = ba + 8'(k);
            id_weight_i = bw + 8'(k);
            while (!id_ready_o && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) chk("id_ready_wait", t, 0);
            @(negedge clk);
            id_valid_i = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic w, input logic [7:0] tx, input logic [7:0] ty,
                             input logic [7:0] dat);
        int t;
        t = 0;
        d_valid_i = 1'b1;
        d_is_weight_i = w;
        d_tag_x_i = tx;
        d_tag_y_i = ty;
        d_data_i = dat;
        while (!d_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("d_ready_wait", t, 0);
        @(negedge clk);
        d_valid_i = 1'b0;
    endtask

    task automatic finish_job(input bit pulse_go);
        int t;
        t = 0;
        while (!start_seen && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("start_seen", start_seen, 1);
        repeat (2) @(negedge clk);
        if (pulse_go) begin
            go_i = 1'b1;
            @(negedge clk);
            go_i = 1'b0;
            chk("go_ignored_busy", busy_o, 1);
        end
        flag_done_i = 1'b1;
        @(negedge clk);
        flag_done_i = 1'b0;
        chk("done_pulse", done_o, 1);
        chk("busy_in_done", busy_o, 1);
        @(negedge clk);
        chk("busy_after_done", busy_o, 0);
        chk("done_after", done_o, 0);
    endtask

    initial begin
        nrst = 1'b0;
        go_i = 1'b0;
        load_len_i = '0;
        id_valid_i = 1'b0;
        id_act_i = '0;
        id_weight_i = '0;
        d_valid_i = 1'b0;
        d_is_weight_i = 1'b0;
        d_tag_x_i = '0;
        d_tag_y_i = '0;
        d_data_i = '0;
        flag_done_i = 1'b0;
        clear_events();
        repeat (3) @(negedge clk);
        chk("reset_tags", {act_tag_x_o, act_tag_y_o, weight_tag_x_o, weight_tag_y_o}, 32'hFFFF_FFFF);
        chk("reset_ctrl", {busy_o, cluster_enable_o, id_ready_o, d_ready_o, start_compute_o}, 0);
        nrst = 1'b1;
        @(negedge clk);

        // Job 1: gapless IDs 0..11, four back-to-back data words
        start_job(16'd4);
        chk("busy_c1", busy_o, 1);
        chk("id_ready_c1", id_ready_o, 1);
        send_ids(0, 8'h00, 8'h00);
        chk("first_scan", {act_id_scan_o, weight_id_scan_o}, 16'h0B0B);
        send_word(1'b1, 8'h01, 8'h02, 8'h7F);
        chk("wren_cycle", wren_cyc - go_cyc, 25);
        chk("wren_once", wren_cnt, 1);
        chk("first_dready_cycle", dr_cyc - go_cyc, 26);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("chain_a1[%0d]", i), snap_a[i], 8'(i));
            chk($sformatf("chain_w1[%0d]", i), snap_w[i], 8'(i));
        end
        chk("word1_bus", {w_data_o, weight_tag_x_o, weight_tag_y_o, a_data_o, act_tag_x_o, act_tag_y_o},
            48'h7F0102_00FFFF);
        send_word(1'b0, 8'h00, 8'h01, 8'h80);
        chk("word2_bus", {a_data_o, act_tag_x_o, act_tag_y_o, w_data_o, weight_tag_x_o, weight_tag_y_o},
            48'h800001_00FFFF);
        send_word(1'b1, 8'h03, 8'h04, 8'h05);
        send_word(1'b0, 8'h05, 8'h06, 8'hFE);
        chk("word4_start", start_compute_o, 1);
        chk("word4_bus", {a_data_o, act_tag_x_o, act_tag_y_o}, 24'hFE0506);
        finish_job(1'b1);
        repeat (2) @(negedge clk);
        chk("go_in_wait_ignored", busy_o, 0);

        // Job 2: IDs with 3-cycle gaps, no data words
        start_job(16'd0);
        send_ids(3, 8'h20, 8'h50);
        finish_job(1'b0);
        chk("len0_start_after_wren", start_cyc - wren_cyc, 1);
        chk("wren_once_2", wren_cnt, 1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("chain_a2[%0d]", i), snap_a[i], 8'h20 + 8'(i));
            chk($sformatf("chain_w2[%0d]", i), snap_w[i], 8'h50 + 8'(i));
        end

        // Job 3: reset in the middle of the data phase, then a clean job
        start_job(16'd5);
        send_ids(0, 8'h30, 8'h60);
        send_word(1'b1, 8'h01, 8'h01, 8'h11);
        send_word(1'b0, 8'h02, 8'h02, 8'h22);
        flag_done_i = 1'b1;
        @(negedge clk);
        flag_done_i = 1'b0;
        chk("flag_in_load_ignored", {d_ready_o, done_o, busy_o}, 3'b101);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        chk("midreset_ctrl", {busy_o, cluster_enable_o, d_ready_o, id_ready_o, start_compute_o, done_o}, 0);
        chk("midreset_bus", {w_data_o, weight_tag_x_o, weight_tag_y_o, a_data_o, act_tag_x_o, act_tag_y_o},
            48'h00FFFF_00FFFF);
        clear_events();
        repeat (3) @(negedge clk);
        chk("no_wren_after_reset", wren_cnt, 0);
        chk("no_start_after_reset", start_seen, 0);
        start_job(16'd1);
        send_ids(0, 8'h40, 8'h70);
        send_word(1'b1, 8'h07, 8'h08, 8'h99);
        chk("job3_bus", {w_data_o, weight_tag_x_o, weight_tag_y_o}, 24'h990708);
        finish_job(1'b0);
        chk("job3_chain0", {snap_a[0], snap_w[0]}, 16'h4070);
        chk("job3_chain11", {snap_a[11], snap_w[11]}, 16'h4B7B);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
